// File: rtl/pipe_chain.sv
// pipe_chain: DEPTH-stage valid/hold pipeline with optional input skid register.
// Each stage is rigid or bubble collapsing. The block also reports an occupancy
// count and supports a synchronous flush. Payload flops carry no reset and only
// load real words, so they stay quiet when bubbles pass through.
module pipe_chain #(
    parameter int DW    = 8,
    parameter int DEPTH = 2,
    parameter int RIGID = 0,
    parameter int SKID  = 0,
    localparam int CW   = $clog2(DEPTH + 2)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          flush,
    input  logic          di_valid,
    input  logic [DW-1:0] di,
    output logic          di_hold,
    output logic          q_valid,
    output logic [DW-1:0] q,
    input  logic          q_hold,
    output logic [CW-1:0] count
);

    localparam logic RIGID_B = (RIGID != 0);

    logic [DEPTH-1:0] v;
    logic [DW-1:0]    d     [DEPTH];
    logic [DEPTH:0]   h;
    logic [DEPTH-1:0] src_v;
    logic [DW-1:0]    src_d [DEPTH];
    logic             s0_valid;
    logic [DW-1:0]    s0_data;
    logic             skid_valid;

    // Hold ripples upstream from q_hold. In collapsing mode an empty stage
    // breaks the chain, so it can still accept a word.
    always_comb begin
        logic run;
        run      = q_hold;
        h[DEPTH] = q_hold;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            run  = run & (v[k] | RIGID_B);
            h[k] = run;
        end
    end

    // Each stage takes its input from the previous stage; stage 0 takes it from the input side.
    always_comb begin
        src_v[0] = s0_valid;
        src_d[0] = s0_data;
        for (int k = 1; k < DEPTH; k++) begin
            src_v[k] = v[k-1];
            src_d[k] = d[k-1];
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic [DW-1:0] skid_d;

            // The skid slot holds a word while stage 0 is blocked. It is
            // filled only when empty and drained once stage 0 frees up.
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn)
                    skid_valid <= 1'b0;
                else if (flush)
                    skid_valid <= 1'b0;
                else
                    skid_valid <= h[0] & (skid_valid | di_valid);
            end

            // The skid payload is captured only on a real accept into a blocked stage 0.
            always_ff @(posedge clk) begin
                if (!skid_valid && di_valid && h[0])
                    skid_d <= di;
            end

            // The skid word has priority over di. di_hold is skid_valid, so
            // di is never accepted while the skid slot drains.
            assign s0_valid = skid_valid | di_valid;
            assign s0_data  = skid_valid ? skid_d : di;
            assign di_hold  = skid_valid;
        end else begin : g_direct
            assign skid_valid = 1'b0;
            assign s0_valid   = di_valid;
            assign s0_data    = di;
            assign di_hold    = h[0];
        end
    endgenerate

    // Stage valid bits. Flush wins over any advance, and the word on di in
    // the flush cycle is dropped.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            v <= '0;
        else if (flush)
            v <= '0;
        else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (!h[k])
                    v[k] <= src_v[k];
            end
        end
    end

    // A stage's payload loads only when it advances and its source holds a real word.
    always_ff @(posedge clk) begin
        for (int k = 0; k < DEPTH; k++) begin
            if (!h[k] && src_v[k])
                d[k] <= src_d[k];
        end
    end

    assign q_valid = v[DEPTH-1];
    assign q       = d[DEPTH-1];

    // Occupancy is the popcount of the stage valid bits plus the skid slot.
    always_comb begin
        count = CW'(skid_valid);
        for (int k = 0; k < DEPTH; k++)
            count = count + CW'(v[k]);
    end

endmodule

// File: tb/tb_pipe_chain.sv
// Bench for pipe_chain: three configurations share one stimulus bus.
// The instances are A (DEPTH3 collapsing), R (DEPTH3 rigid) and S (DEPTH2 with skid).
// A scoreboard per instance checks ordering; directed checks cover timing.
module tb_pipe_chain;

    logic       clk;
    logic       resetn;
    logic       flush;
    logic       di_valid;
    logic [7:0] di;
    logic       q_hold;

    logic       di_hold_a, q_valid_a;
    logic [7:0] q_a;
    logic [2:0] count_a;
    logic       di_hold_r, q_valid_r;
    logic [7:0] q_r;
    logic [2:0] count_r;
    logic       di_hold_s, q_valid_s;
    logic [7:0] q_s;
    logic [1:0] count_s;

    int errors = 0;
    int checks = 0;

    pipe_chain #(.DW(8), .DEPTH(3), .RIGID(0), .SKID(0)) u_a (
        .clk(clk), .resetn(resetn), .flush(flush), .di_valid(di_valid), .di(di),
        .di_hold(di_hold_a), .q_valid(q_valid_a), .q(q_a), .q_hold(q_hold), .count(count_a));

    pipe_chain #(.DW(8), .DEPTH(3), .RIGID(1), .SKID(0)) u_r (
        .clk(clk), .resetn(resetn), .flush(flush), .di_valid(di_valid), .di(di),
        .di_hold(di_hold_r), .q_valid(q_valid_r), .q(q_r), .q_hold(q_hold), .count(count_r));

    pipe_chain #(.DW(8), .DEPTH(2), .RIGID(0), .SKID(1)) u_s (
        .clk(clk), .resetn(resetn), .flush(flush), .di_valid(di_valid), .di(di),
        .di_hold(di_hold_s), .q_valid(q_valid_s), .q(q_s), .q_hold(q_hold), .count(count_s));

    logic       dh [3];
    logic       qv [3];
    logic [7:0] qd [3];
    assign dh[0] = di_hold_a;  assign qv[0] = q_valid_a;  assign qd[0] = q_a;
    assign dh[1] = di_hold_r;  assign qv[1] = q_valid_r;  assign qd[1] = q_r;
    assign dh[2] = di_hold_s;  assign qv[2] = q_valid_s;  assign qd[2] = q_s;

    logic [7:0] sbq [3][$];
    logic [7:0] mon_exp;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard monitor: sampled mid-cycle, it evaluates the handshakes due on the next rising edge.
    always @(negedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < 3; i++) sbq[i].delete();
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (qv[i] && !q_hold) begin
                    checks++;
                    if (sbq[i].size() == 0) begin
                        errors++;
                        $display("FAIL sb_extra inst%0d: got q=%h, expected no word", i, qd[i]);
                    end else begin
                        mon_exp = sbq[i].pop_front();
                        if (qd[i] !== mon_exp) begin
                            errors++;
                            $display("FAIL sb_order inst%0d: got q=%h expected %h", i, qd[i], mon_exp);
                        end
                    end
                end
                if (flush)
                    sbq[i].delete();
                else if (di_valid && !dh[i])
                    sbq[i].push_back(di);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drain(input int n);
        di_valid = 1'b0;
        q_hold   = 1'b0;
        flush    = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
        for (int i = 0; i < 3; i++)
            chk($sformatf("sb_empty inst%0d", i), 32'(sbq[i].size()), 32'd0);
    endtask

    int idx;

    initial begin
        resetn = 1'b0; flush = 1'b0; di_valid = 1'b0; di = 8'h00; q_hold = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst q_valid_a", 32'(q_valid_a), 32'd0);
        chk("rst count_a",   32'(count_a),   32'd0);
        chk("rst di_hold_a", 32'(di_hold_a), 32'd0);
        chk("rst q_valid_r", 32'(q_valid_r), 32'd0);
        chk("rst q_valid_s", 32'(q_valid_s), 32'd0);
        chk("rst count_s",   32'(count_s),   32'd0);
        chk("rst di_hold_s", 32'(di_hold_s), 32'd0);
        resetn = 1'b1;

        // Stream 0x01..0x0A with no hold.
        for (int k = 0; k < 14; k++) begin
            di_valid = (k < 10);
            di       = 8'(k + 1);
            q_hold   = 1'b0;
            @(negedge clk);
            chk($sformatf("stream a q_valid c%0d", k), 32'(q_valid_a), 32'(k >= 3 && k <= 12));
            if (k >= 3 && k <= 12) chk($sformatf("stream a q c%0d", k), 32'(q_a), 32'(k - 2));
            if (k >= 3 && k <= 10) chk($sformatf("stream a count c%0d", k), 32'(count_a), 32'd3);
            chk($sformatf("stream s q_valid c%0d", k), 32'(q_valid_s), 32'(k >= 2 && k <= 11));
            chk($sformatf("stream s di_hold c%0d", k), 32'(di_hold_s), 32'd0);
            @(posedge clk); #1;
        end
        drain(8);

        // Collapsing fill on A: 0x55, then 0x10.. under q_hold for 5 cycles.
        idx = 0;
        for (int k = 0; k < 11; k++) begin
            q_hold   = (k >= 1 && k <= 5);
            di_valid = (idx < 4);
            di       = (idx == 0) ? 8'h55 : 8'(8'h10 + idx - 1);
            @(negedge clk);
            chk($sformatf("fill a di_hold c%0d", k), 32'(di_hold_a), 32'(k >= 3 && k <= 5));
            chk($sformatf("fill a q_valid c%0d", k), 32'(q_valid_a), 32'(k >= 3 && k <= 9));
            if (k == 3) chk("fill a count", 32'(count_a), 32'd3);
            if (k >= 3 && k <= 6) chk($sformatf("fill a q c%0d", k), 32'(q_a), 32'h55);
            if (k == 7) chk("fill a q c7", 32'(q_a), 32'h10);
            if (k == 8) chk("fill a q c8", 32'(q_a), 32'h11);
            if (k == 9) chk("fill a q c9", 32'(q_a), 32'h12);
            if (di_valid && !di_hold_a) idx++;
            @(posedge clk); #1;
        end
        chk("fill a accepted", 32'(idx), 32'd4);
        drain(8);

        // Rigid R: A0, bubble, A1 with q_hold for 2 cycles.
        idx = 0;
        for (int k = 0; k < 9; k++) begin
            q_hold   = (k == 2 || k == 3);
            di_valid = (idx == 0 || idx == 2);
            di       = (idx == 0) ? 8'hA0 : 8'hA1;
            @(negedge clk);
            chk($sformatf("rigid r di_hold c%0d", k), 32'(di_hold_r), 32'(k == 2 || k == 3));
            chk($sformatf("rigid r q_valid c%0d", k), 32'(q_valid_r), 32'(k == 5 || k == 7));
            if (k == 3) chk("rigid r count", 32'(count_r), 32'd1);
            if (k == 5) chk("rigid r q c5", 32'(q_r), 32'hA0);
            if (k == 7) chk("rigid r q c7", 32'(q_r), 32'hA1);
            if (idx < 3 && !di_hold_r) idx++;
            @(posedge clk); #1;
        end
        chk("rigid r items", 32'(idx), 32'd3);
        drain(8);

        // Skid S: hold for 6 cycles with di_valid high.
        idx = 0;
        for (int k = 0; k < 11; k++) begin
            q_hold   = (k <= 5);
            di_valid = (idx < 4);
            di       = 8'(8'h20 + idx);
            @(negedge clk);
            chk($sformatf("skid s di_hold c%0d", k), 32'(di_hold_s), 32'(k >= 3 && k <= 6));
            chk($sformatf("skid s q_valid c%0d", k), 32'(q_valid_s), 32'(k >= 2 && k <= 9));
            if (k == 3) chk("skid s count", 32'(count_s), 32'd3);
            if (k >= 2 && k <= 6) chk($sformatf("skid s q c%0d", k), 32'(q_s), 32'h20);
            if (k == 7) chk("skid s q c7", 32'(q_s), 32'h21);
            if (k == 8) chk("skid s q c8", 32'(q_s), 32'h22);
            if (k == 9) chk("skid s q c9", 32'(q_s), 32'h23);
            if (di_valid && !di_hold_s) idx++;
            @(posedge clk); #1;
        end
        chk("skid s accepted", 32'(idx), 32'd4);
        drain(8);

        // Flush with A full and di_valid high; 0x3F must never emerge.
        for (int k = 0; k < 9; k++) begin
            flush    = (k == 3);
            q_hold   = (k < 3);
            di_valid = (k <= 3);
            di       = (k == 3) ? 8'h3F : 8'(8'h30 + k);
            @(negedge clk);
            if (k == 3) begin
                chk("flush a count pre", 32'(count_a),   32'd3);
                chk("flush a q_valid pre", 32'(q_valid_a), 32'd1);
                chk("flush a q pre",     32'(q_a),       32'h30);
                chk("flush s count pre", 32'(count_s),   32'd3);
            end
            if (k >= 4) chk($sformatf("flush a q_valid c%0d", k), 32'(q_valid_a), 32'd0);
            if (k == 4) begin
                chk("flush a count post", 32'(count_a), 32'd0);
                chk("flush r count post", 32'(count_r), 32'd0);
                chk("flush s count post", 32'(count_s), 32'd0);
            end
            @(posedge clk); #1;
        end
        drain(6);

        // Random traffic with a reset pulse mid-stream.
        for (int k = 0; k < 10000; k++) begin
            di_valid = ($urandom_range(0, 3) != 0);
            di       = 8'($urandom);
            q_hold   = ($urandom_range(0, 3) == 0);
            if (k == 6000) begin
                #2 resetn = 1'b0;
                #1;
                chk("midrst a q_valid", 32'(q_valid_a), 32'd0);
                chk("midrst a count",   32'(count_a),   32'd0);
                chk("midrst r q_valid", 32'(q_valid_r), 32'd0);
                chk("midrst r count",   32'(count_r),   32'd0);
                chk("midrst s q_valid", 32'(q_valid_s), 32'd0);
                chk("midrst s count",   32'(count_s),   32'd0);
                chk("midrst s di_hold", 32'(di_hold_s), 32'd0);
                @(posedge clk); #1;
                resetn = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        drain(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
